norm_shifter: RTL
=================

Name: norm_shifter

Overview:
- Sequential normalizing left-shifter directly downstream of the leading-zero detector.
- Takes an operand and its leading-zero count, then shifts the operand left one bit per cycle until its MSB is 1.
- Produces the normalized word, a truncated mantissa with a sticky LSB, and the position (exponent) of the leading one.
- Its outputs feed the approximate-multiplier datapath.

Parameters:
- WIDTH, 8, operand width in bits.
- CNT_W, 4, width of the count and exponent fields. Must hold the value WIDTH.
- TRUNC_W, 4, number of MSBs kept in the truncated mantissa (TRUNC_W < WIDTH).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse, sampled only in IDLE.
- in_data  in  WIDTH  operand to normalize.
- lz_cnt  in  CNT_W  leading-zero count from the LZD.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; results valid from this cycle onward.
- norm_out  out  WIDTH  normalized operand.
- trunc_out  out  TRUNC_W  top TRUNC_W bits of norm_out, with a sticky LSB.
- exp_out  out  CNT_W  index of the leading one, equal to WIDTH-1-shifts.
- zero_flag  out  1  set when the operand was zero.

Behaviour:
- Reset: asynchronous and active-low. While rst_n=0:
  - state=IDLE, internal shift register and counter cleared.
  - busy=0, done=0, norm_out=0, trunc_out=0, exp_out=0, zero_flag=0.
  - An assertion mid-operation aborts the job; no done is produced.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On a clock edge with start=1: capture in_data into sh; set rem=min(lz_cnt, WIDTH); set shifts=0; go to SHIFT.
  - If in_data==0, rem is forced to 0 and the zero condition is latched internally.
  - start=0: stay in IDLE.
- SHIFT, each edge:
  - If rem==0, or sh[WIDTH-1]==1, or the operand is zero: go to DONE and register the outputs.
  - Otherwise: sh<=sh<<1 (zero fill), rem<=rem-1, shifts<=shifts+1.
  - The MSB check means a count larger than the true leading-zero count never shifts out a one.
  - A count smaller than the true count leaves the result unnormalized, with MSB=0; no error is flagged.
- Output registration, on the edge entering DONE:
  - norm_out = sh.
  - exp_out = WIDTH-1-shifts.
  - trunc_out = sh[WIDTH-1 -: TRUNC_W], with bit0 ORed with |sh[WIDTH-TRUNC_W-1:0].
  - zero_flag = (operand==0). When zero: norm_out=0, trunc_out=0, exp_out=0.
- DONE: done=1 for exactly one cycle, then unconditionally go to IDLE.
- Result hold: outputs keep their values until the next DONE entry or reset. done is 0 outside the DONE state.
- Latency: with k = actual shifts performed, done is high in the cycle beginning k+1 edges after the start-sampling edge. The next start is accepted one cycle after done.
- start while busy (SHIFT or DONE): ignored, with no effect on the job in progress. start in the same cycle done is high is also ignored.
- in_data and lz_cnt are don't-care except at the start-sampling edge.

Test Plan:
- in=00000111, lz=5 -> after 6 edges: norm=11100000, trunc=1110, exp=2, zero_flag=0; done high exactly 1 cycle; busy high from start edge until done ends.
- in=10000000, lz=0 -> done 1 edge after start: norm=10000000, trunc=1000, exp=7. Then in=01000000, lz=1 -> done after 2 edges: norm=10000000, exp=6.
- in=00000000, lz=8 -> done after 1 edge: zero_flag=1, norm=0, trunc=0, exp=0. Then in=00010101, lz=3 -> norm=10101000, trunc=1011 (sticky set), exp=4, zero_flag=0.
- Inconsistent count: in=00100000, lz=5 -> stops after 2 shifts: norm=10000000, exp=5, done after 3 edges.
- Start asserted every cycle during a lz=5 job -> exactly one done pulse; outputs belong to the first operand. The next start after done is accepted.
- rst_n pulsed low for 2 cycles mid-SHIFT -> all outputs go 0 asynchronously; no done pulse; a new start afterwards completes normally with the correct result.

Source files
------------

// File: rtl/norm_shifter.sv
// rtl/norm_shifter.sv - sequential normalizing left-shifter after the leading-zero detector
module norm_shifter #(
  parameter int WIDTH   = 8,
  parameter int CNT_W   = 4,
  parameter int TRUNC_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [CNT_W-1:0]   lz_cnt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   norm_out,
  output logic [TRUNC_W-1:0] trunc_out,
  output logic [CNT_W-1:0]   exp_out,
  output logic               zero_flag
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [CNT_W-1:0] WIDTH_C    = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] LAST_IDX_C = CNT_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sh_q, sh_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   shifts_q, shifts_d;
  logic               zero_q, zero_d;
  logic [WIDTH-1:0]   norm_q, norm_d;
  logic [TRUNC_W-1:0] trunc_q, trunc_d;
  logic [CNT_W-1:0]   exp_q, exp_d;
  logic               zflag_q, zflag_d;
  logic [TRUNC_W-1:0] trunc_calc;

  // Discarded low bits collapse into the mantissa LSB so rounding still sees them.
  always_comb begin
    trunc_calc    = sh_q[WIDTH-1 -: TRUNC_W];
    trunc_calc[0] = trunc_calc[0] | (|sh_q[WIDTH-TRUNC_W-1:0]);
  end

  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    rem_d    = rem_q;
    shifts_d = shifts_q;
    zero_d   = zero_q;
    norm_d   = norm_q;
    trunc_d  = trunc_q;
    exp_d    = exp_q;
    zflag_d  = zflag_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sh_d     = in_data;
          shifts_d = '0;
          zero_d   = (in_data == '0);
          if (in_data == '0)        rem_d = '0;
          else if (lz_cnt > WIDTH_C) rem_d = WIDTH_C;
          else                      rem_d = lz_cnt;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        // The MSB test stops early when the supplied count overstates the leading zeros.
        if (rem_q == '0 || sh_q[WIDTH-1] || zero_q) begin
          state_d = DONE;
          zflag_d = zero_q;
          if (zero_q) begin
            norm_d  = '0;
            trunc_d = '0;
            exp_d   = '0;
          end else begin
            norm_d  = sh_q;
            trunc_d = trunc_calc;
            exp_d   = LAST_IDX_C - shifts_q;
          end
        end else begin
          sh_d     = sh_q << 1;
          rem_d    = rem_q - 1'b1;
          shifts_d = shifts_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sh_q     <= '0;
      rem_q    <= '0;
      shifts_q <= '0;
      zero_q   <= 1'b0;
      norm_q   <= '0;
      trunc_q  <= '0;
      exp_q    <= '0;
      zflag_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_q     <= sh_d;
      rem_q    <= rem_d;
      shifts_q <= shifts_d;
      zero_q   <= zero_d;
      norm_q   <= norm_d;
      trunc_q  <= trunc_d;
      exp_q    <= exp_d;
      zflag_q  <= zflag_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign norm_out  = norm_q;
  assign trunc_out = trunc_q;
  assign exp_out   = exp_q;
  assign zero_flag = zflag_q;

endmodule
